// File: rtl/pixel_packet_spi_tx.sv
// Packs camera pixels into packets, buffers them in a packet FIFO and shifts them over a multi-lane SPI-style link.
// Define SPI_TX_CRC8_EN to append a CRC-8 (poly 0x07) after the data beats of every packet.
module pixel_packet_spi_tx #(
    parameter int PIXEL_WIDTH       = 8,
    parameter int PIXELS_PER_PACKET = 4,
    parameter int LINES             = 4,
    parameter int FIFO_DEPTH        = 16,
    parameter int DATA_CLK_PERIOD   = 12
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [PIXEL_WIDTH-1:0]      pixel_in,
    input  logic                        pixel_valid_in,
    input  logic                        line_last_in,
    input  logic                        frame_start_in,
    output logic [LINES-1:0]            chip_data_out,
    output logic                        chip_clk_out,
    output logic                        chip_sel_out,
    output logic                        chip_last_out,
    output logic                        chip_sof_out,
    output logic                        overflow_out,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_out
);

    localparam int PACKET_BITS = PIXEL_WIDTH * PIXELS_PER_PACKET;
    localparam int BEATS       = PACKET_BITS / LINES;
    localparam int HALF_PERIOD = DATA_CLK_PERIOD / 2;
    localparam int ADDR_W      = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W     = ADDR_W + 1;
    localparam int SLOT_W      = (PIXELS_PER_PACKET > 1) ? $clog2(PIXELS_PER_PACKET) : 1;
    localparam int PHASE_W     = $clog2(DATA_CLK_PERIOD);
    localparam int BEAT_W      = $clog2(BEATS + 8);
`ifdef SPI_TX_CRC8_EN
    localparam int CRC_BEATS   = 8 / LINES;
`endif

    typedef struct packed {
        logic                   sof;
        logic                   last;
        logic [PACKET_BITS-1:0] data;
    } packet_t;

`ifdef SPI_TX_CRC8_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CRC, S_GAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`endif

    // ---------------- packer ----------------
    logic [PACKET_BITS-1:0] pack_data;
    logic [SLOT_W-1:0]      pix_cnt;
    logic                   sof_pending;
    logic [SLOT_W-1:0]      slot;
    logic [PACKET_BITS-1:0] pack_merged;
    logic                   pack_complete;
    logic                   push_valid;
    packet_t                push_pkt;

    // A frame start restarts the packet, so a coincident pixel lands in slot 0.
    always_comb begin
        slot        = frame_start_in ? '0 : pix_cnt;
        pack_merged = frame_start_in ? '0 : pack_data;
        for (int k = 0; k < PIXELS_PER_PACKET; k++) begin
            if (slot == SLOT_W'(k)) begin
                pack_merged[PACKET_BITS-1-k*PIXEL_WIDTH -: PIXEL_WIDTH] = pixel_in;
            end
        end
        pack_complete = pixel_valid_in &&
                        ((slot == SLOT_W'(PIXELS_PER_PACKET - 1)) || line_last_in);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pack_data   <= '0;
            pix_cnt     <= '0;
            sof_pending <= 1'b0;
            push_valid  <= 1'b0;
            push_pkt    <= '0;
        end else begin
            push_valid <= pack_complete;
            if (pack_complete) begin
                push_pkt.data <= pack_merged;
                push_pkt.last <= line_last_in;
                push_pkt.sof  <= sof_pending | frame_start_in;
            end
            if (pixel_valid_in) begin
                if (pack_complete) begin
                    pack_data <= '0;
                    pix_cnt   <= '0;
                end else begin
                    pack_data <= pack_merged;
                    pix_cnt   <= slot + 1'b1;
                end
            end else if (frame_start_in) begin
                pack_data <= '0;
                pix_cnt   <= '0;
            end
            if (pack_complete) begin
                sof_pending <= 1'b0;
            end else if (frame_start_in) begin
                sof_pending <= 1'b1;
            end
        end
    end

    // ---------------- packet FIFO ----------------
    packet_t              fifo_mem [FIFO_DEPTH];
    logic [ADDR_W:0]      wr_ptr;
    logic [ADDR_W:0]      rd_ptr;
    logic [LEVEL_W-1:0]   level;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push_accept;
    logic                 push_drop;
    logic                 pop;
    packet_t              fifo_head;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    always_comb begin
        level       = wr_ptr - rd_ptr;
        fifo_full   = (level == LEVEL_W'(FIFO_DEPTH));
        fifo_empty  = (level == '0);
        push_accept = push_valid && (!fifo_full || pop);
        push_drop   = push_valid && fifo_full && !pop;
        fifo_head   = fifo_mem[rd_ptr[ADDR_W-1:0]];
    end

    always_ff @(posedge clk_in) begin
        if (push_accept) begin
            fifo_mem[wr_ptr[ADDR_W-1:0]] <= push_pkt;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow_out <= 1'b0;
        end else begin
            if (push_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_drop) begin
                overflow_out <= 1'b1;
            end else if (frame_start_in) begin
                overflow_out <= 1'b0;
            end
        end
    end

    assign fifo_level_out = level;

    // ---------------- sender ----------------
    state_t                 state;
    state_t                 state_next;
    logic [PHASE_W-1:0]     phase_cnt;
    logic [BEAT_W-1:0]      beat_cnt;
    logic [PACKET_BITS-1:0] shift_reg;
    logic                   cur_last;
    logic                   cur_sof;
    logic                   period_end;
    logic                   sending;

`ifdef SPI_TX_CRC8_EN
    logic [7:0]             crc_reg;
    logic [PACKET_BITS-1:0] crc_aligned;

    function automatic logic [7:0] crc8(input logic [PACKET_BITS-1:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = PACKET_BITS - 1; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    always_comb begin
        crc_aligned = '0;
        crc_aligned[PACKET_BITS-1 -: 8] = crc_reg;
    end
`endif

    assign period_end = (phase_cnt == PHASE_W'(DATA_CLK_PERIOD - 1));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Lane outputs are decoded straight from registered state so cs, dclk and data move together.
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        sending       = 1'b0;
        chip_sel_out  = 1'b1;
        chip_clk_out  = 1'b0;
        chip_data_out = '0;
        chip_last_out = 1'b0;
        chip_sof_out  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sending = 1'b1;
                if (period_end && beat_cnt == BEAT_W'(BEATS - 1)) begin
`ifdef SPI_TX_CRC8_EN
                    state_next = S_CRC;
`else
                    state_next = S_GAP;
`endif
                end
            end
`ifdef SPI_TX_CRC8_EN
            S_CRC: begin
                sending = 1'b1;
                if (period_end && beat_cnt == BEAT_W'(CRC_BEATS - 1)) begin
                    state_next = S_GAP;
                end
            end
`endif
            S_GAP: begin
                if (phase_cnt == PHASE_W'(HALF_PERIOD - 1)) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (sending) begin
            chip_sel_out  = 1'b0;
            chip_clk_out  = (phase_cnt >= PHASE_W'(HALF_PERIOD));
            chip_data_out = shift_reg[PACKET_BITS-1 -: LINES];
            chip_last_out = cur_last;
            chip_sof_out  = cur_sof;
        end
    end

    // Shifting on the dclk falling edge keeps lane data stable across the rising edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            phase_cnt <= '0;
            beat_cnt  <= '0;
            shift_reg <= '0;
            cur_last  <= 1'b0;
            cur_sof   <= 1'b0;
`ifdef SPI_TX_CRC8_EN
            crc_reg   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    phase_cnt <= '0;
                    beat_cnt  <= '0;
                    if (pop) begin
                        shift_reg <= fifo_head.data;
                        cur_last  <= fifo_head.last;
                        cur_sof   <= fifo_head.sof;
`ifdef SPI_TX_CRC8_EN
                        crc_reg   <= crc8(fifo_head.data);
`endif
                    end
                end
                S_GAP: begin
                    phase_cnt <= (state_next == S_IDLE) ? '0 : phase_cnt + 1'b1;
                end
                default: begin
                    if (period_end) begin
                        phase_cnt <= '0;
                        beat_cnt  <= (state_next != state) ? '0 : beat_cnt + 1'b1;
`ifdef SPI_TX_CRC8_EN
                        if (state == S_SHIFT && state_next == S_CRC) begin
                            shift_reg <= crc_aligned;
                        end else begin
                            shift_reg <= shift_reg << LINES;
                        end
`else
                        shift_reg <= shift_reg << LINES;
`endif
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_packet_spi_tx.sv
// Directed bench for pixel_packet_spi_tx with default parameters; observes the link on every falling clk edge.
module tb_pixel_packet_spi_tx;

`ifdef SPI_TX_CRC8_EN
    localparam int EXTRA_BEATS = 2;
`else
    localparam int EXTRA_BEATS = 0;
`endif

    logic       clk_in;
    logic       rst_in;
    logic [7:0] pixel_in;
    logic       pixel_valid_in;
    logic       line_last_in;
    logic       frame_start_in;
    logic [3:0] chip_data_out;
    logic       chip_clk_out;
    logic       chip_sel_out;
    logic       chip_last_out;
    logic       chip_sof_out;
    logic       overflow_out;
    logic [4:0] fifo_level_out;

    int vectors = 0;
    int errors  = 0;

    int         cap_wait;
    int         cap_low;
    int         cap_nbeats;
    logic [3:0] cap_beat [0:15];
    logic       cap_last;
    logic       cap_sof;
    logic       cap_flag_bad;
    logic       cap_timeout;
    logic       cap_idle_clk;
    logic [3:0] cap_idle_data;

    pixel_packet_spi_tx dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .pixel_in       (pixel_in),
        .pixel_valid_in (pixel_valid_in),
        .line_last_in   (line_last_in),
        .frame_start_in (frame_start_in),
        .chip_data_out  (chip_data_out),
        .chip_clk_out   (chip_clk_out),
        .chip_sel_out   (chip_sel_out),
        .chip_last_out  (chip_last_out),
        .chip_sof_out   (chip_sof_out),
        .overflow_out   (overflow_out),
        .fifo_level_out (fifo_level_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive(input logic [7:0] pix, input logic valid, input logic last, input logic fs);
        pixel_in       = pix;
        pixel_valid_in = valid;
        line_last_in   = last;
        frame_start_in = fs;
        @(negedge clk_in);
        pixel_in       = 8'h00;
        pixel_valid_in = 1'b0;
        line_last_in   = 1'b0;
        frame_start_in = 1'b0;
    endtask

    // Waits for cs to fall, then records the whole cs-low window beat by beat.
    task automatic capture_packet();
        logic prev_clk;
        cap_wait     = 0;
        cap_low      = 0;
        cap_nbeats   = 0;
        cap_flag_bad = 1'b0;
        cap_timeout  = 1'b0;
        while (chip_sel_out === 1'b1 && cap_wait < 2000) begin
            @(negedge clk_in);
            cap_wait++;
        end
        if (chip_sel_out !== 1'b0) begin
            cap_timeout = 1'b1;
            return;
        end
        cap_last = chip_last_out;
        cap_sof  = chip_sof_out;
        prev_clk = 1'b0;
        while (chip_sel_out === 1'b0 && cap_low < 1000) begin
            cap_low++;
            if (chip_last_out !== cap_last || chip_sof_out !== cap_sof) cap_flag_bad = 1'b1;
            if (chip_clk_out === 1'b1 && prev_clk === 1'b0) begin
                if (cap_nbeats < 16) cap_beat[cap_nbeats] = chip_data_out;
                cap_nbeats++;
            end
            prev_clk = chip_clk_out;
            @(negedge clk_in);
        end
        cap_idle_clk  = chip_clk_out;
        cap_idle_data = chip_data_out;
    endtask

    function automatic logic [31:0] cap_word();
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < 8; i++) w = {w[27:0], cap_beat[i]};
        return w;
    endfunction

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        vectors++; if (chip_sel_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs: got %b expected 1", chip_sel_out); end
        vectors++; if (chip_clk_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_dclk: got %b expected 0", chip_clk_out); end
        vectors++; if (chip_data_out !== 4'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", chip_data_out); end
        vectors++; if (chip_last_out !== 1'b0 || chip_sof_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got last=%b sof=%b expected 0 0", chip_last_out, chip_sof_out); end
        vectors++; if (overflow_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow_out); end
        vectors++; if (fifo_level_out !== 5'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level_out); end
        rst_in = 1'b1;
        repeat (4) @(negedge clk_in);
        vectors++; if (chip_sel_out !== 1'b1) begin errors++; $display("[TB] FAIL idle_cs: got %b expected 1", chip_sel_out); end
    endtask

    task automatic test_basic_packet();
        drive(8'h11, 1'b1, 1'b0, 1'b0);
        drive(8'h22, 1'b1, 1'b0, 1'b0);
        drive(8'h33, 1'b1, 1'b0, 1'b0);
        drive(8'h44, 1'b1, 1'b0, 1'b0);
        capture_packet();
        vectors++;
        if (cap_timeout) begin errors++; $display("[TB] FAIL basic_timeout: cs never fell"); return; end
        vectors++; if (cap_wait != 2) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 2", cap_wait); end
        vectors++; if (cap_low != 96 + 12 * EXTRA_BEATS) begin errors++; $display("[TB] FAIL basic_cs_low: got %0d expected %0d", cap_low, 96 + 12 * EXTRA_BEATS); end
        vectors++; if (cap_nbeats != 8 + EXTRA_BEATS) begin errors++; $display("[TB] FAIL basic_beats: got %0d expected %0d", cap_nbeats, 8 + EXTRA_BEATS); end
        vectors++; if (cap_word() !== 32'h11223344) begin errors++; $display("[TB] FAIL basic_word: got %h expected 11223344", cap_word()); end
        vectors++; if (cap_last !== 1'b0 || cap_sof !== 1'b0) begin errors++; $display("[TB] FAIL basic_flags: got last=%b sof=%b expected 0 0", cap_last, cap_sof); end
        vectors++; if (cap_flag_bad) begin errors++; $display("[TB] FAIL basic_flag_stable: got unstable expected stable"); end
        vectors++; if (cap_idle_clk !== 1'b0 || cap_idle_data !== 4'h0) begin errors++; $display("[TB] FAIL basic_idle: got dclk=%b data=%h expected 0 0", cap_idle_clk, cap_idle_data); end
    endtask

    task automatic test_line_last_sof();
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        drive(8'hAA, 1'b1, 1'b1, 1'b0);
        capture_packet();
        vectors++;
        if (cap_timeout) begin errors++; $display("[TB] FAIL eol_timeout: cs never fell"); return; end
        vectors++; if (cap_word() !== 32'hAA000000) begin errors++; $display("[TB] FAIL eol_word: got %h expected aa000000", cap_word()); end
        vectors++; if (cap_last !== 1'b1 || cap_sof !== 1'b1) begin errors++; $display("[TB] FAIL eol_flags: got last=%b sof=%b expected 1 1", cap_last, cap_sof); end
        vectors++; if (cap_flag_bad) begin errors++; $display("[TB] FAIL eol_flag_stable: got unstable expected stable"); end
        vectors++; if (chip_last_out !== 1'b0 || chip_sof_out !== 1'b0) begin errors++; $display("[TB] FAIL eol_flags_after: got last=%b sof=%b expected 0 0", chip_last_out, chip_sof_out); end
    endtask

    task automatic test_partial_flush();
        drive(8'h01, 1'b1, 1'b0, 1'b0);
        drive(8'h02, 1'b1, 1'b0, 1'b0);
        drive(8'h55, 1'b1, 1'b0, 1'b1);
        drive(8'h66, 1'b1, 1'b0, 1'b0);
        drive(8'h77, 1'b1, 1'b0, 1'b0);
        drive(8'h88, 1'b1, 1'b0, 1'b0);
        capture_packet();
        vectors++;
        if (cap_timeout) begin errors++; $display("[TB] FAIL flush_timeout: cs never fell"); return; end
        vectors++; if (cap_word() !== 32'h55667788) begin errors++; $display("[TB] FAIL flush_word: got %h expected 55667788", cap_word()); end
        vectors++; if (cap_sof !== 1'b1 || cap_last !== 1'b0) begin errors++; $display("[TB] FAIL flush_flags: got last=%b sof=%b expected 0 1", cap_last, cap_sof); end
        vectors++; if (fifo_level_out !== 5'd0) begin errors++; $display("[TB] FAIL flush_level: got %0d expected 0", fifo_level_out); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] first_word;
        drive(8'h12, 1'b1, 1'b0, 1'b0);
        drive(8'h34, 1'b1, 1'b0, 1'b0);
        drive(8'h56, 1'b1, 1'b0, 1'b0);
        drive(8'h78, 1'b1, 1'b0, 1'b0);
        drive(8'h9A, 1'b1, 1'b0, 1'b0);
        drive(8'hBC, 1'b1, 1'b0, 1'b0);
        drive(8'hDE, 1'b1, 1'b0, 1'b0);
        drive(8'hF0, 1'b1, 1'b0, 1'b0);
        capture_packet();
        vectors++;
        if (cap_timeout) begin errors++; $display("[TB] FAIL b2b_timeout1: cs never fell"); return; end
        first_word = cap_word();
        vectors++; if (first_word !== 32'h12345678) begin errors++; $display("[TB] FAIL b2b_word1: got %h expected 12345678", first_word); end
        capture_packet();
        vectors++;
        if (cap_timeout) begin errors++; $display("[TB] FAIL b2b_timeout2: cs never fell"); return; end
        vectors++; if (cap_wait != 7) begin errors++; $display("[TB] FAIL b2b_gap: got %0d expected 7", cap_wait); end
        vectors++; if (cap_word() !== 32'h9ABCDEF0) begin errors++; $display("[TB] FAIL b2b_word2: got %h expected 9abcdef0", cap_word()); end
        vectors++; if (cap_low != 96 + 12 * EXTRA_BEATS) begin errors++; $display("[TB] FAIL b2b_cs_low: got %0d expected %0d", cap_low, 96 + 12 * EXTRA_BEATS); end
    endtask

`ifdef SPI_TX_CRC8_EN
    task automatic test_crc();
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        drive(8'h01, 1'b1, 1'b0, 1'b0);
        capture_packet();
        vectors++;
        if (cap_timeout) begin errors++; $display("[TB] FAIL crc1_timeout: cs never fell"); return; end
        vectors++; if (cap_beat[8] !== 4'h0 || cap_beat[9] !== 4'h7) begin errors++; $display("[TB] FAIL crc1_beats: got %h %h expected 0 7", cap_beat[8], cap_beat[9]); end
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        capture_packet();
        vectors++;
        if (cap_timeout) begin errors++; $display("[TB] FAIL crc0_timeout: cs never fell"); return; end
        vectors++; if (cap_beat[8] !== 4'h0 || cap_beat[9] !== 4'h0) begin errors++; $display("[TB] FAIL crc0_beats: got %h %h expected 0 0", cap_beat[8], cap_beat[9]); end
    endtask
`endif

    task automatic test_overflow();
        for (int i = 0; i < 20; i++) drive(8'(i + 1), 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk_in);
        vectors++; if (overflow_out !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow_out); end
        vectors++; if (fifo_level_out !== 5'd16) begin errors++; $display("[TB] FAIL ovf_level: got %0d expected 16", fifo_level_out); end
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        vectors++; if (overflow_out !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow_out); end
        vectors++; if (fifo_level_out !== 5'd16) begin errors++; $display("[TB] FAIL ovf_level_kept: got %0d expected 16", fifo_level_out); end
    endtask

    task automatic test_reset_mid_packet();
        int   budget;
        int   rises;
        int   low_after;
        logic prev_clk;
        budget   = 0;
        rises    = 0;
        prev_clk = 1'b0;
        while (rises < 4 && budget < 2000) begin
            if (chip_sel_out === 1'b0 && chip_clk_out === 1'b1 && prev_clk === 1'b0) rises++;
            prev_clk = (chip_sel_out === 1'b0) ? chip_clk_out : 1'b0;
            if (rises < 4) begin
                @(negedge clk_in);
                budget++;
            end
        end
        vectors++;
        if (rises < 4) begin errors++; $display("[TB] FAIL midrst_timeout: got %0d rises expected 4", rises); return; end
        rst_in = 1'b0;
        #1;
        vectors++; if (chip_sel_out !== 1'b1) begin errors++; $display("[TB] FAIL midrst_cs: got %b expected 1", chip_sel_out); end
        vectors++; if (chip_clk_out !== 1'b0) begin errors++; $display("[TB] FAIL midrst_dclk: got %b expected 0", chip_clk_out); end
        vectors++; if (fifo_level_out !== 5'd0) begin errors++; $display("[TB] FAIL midrst_level: got %0d expected 0", fifo_level_out); end
        @(negedge clk_in);
        rst_in    = 1'b1;
        low_after = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_in);
            if (chip_sel_out !== 1'b1 || chip_clk_out !== 1'b0) low_after++;
        end
        vectors++; if (low_after != 0) begin errors++; $display("[TB] FAIL midrst_quiet: got %0d active cycles expected 0", low_after); end
    endtask

    initial begin
        rst_in         = 1'b0;
        pixel_in       = 8'h00;
        pixel_valid_in = 1'b0;
        line_last_in   = 1'b0;
        frame_start_in = 1'b0;
        test_reset();
        test_basic_packet();
        test_line_last_sof();
        test_partial_flush();
        test_back_to_back();
`ifdef SPI_TX_CRC8_EN
        test_crc();
`endif
        test_overflow();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
